// File: rtl/soc_lsu_pkg.sv
// soc_lsu_pkg: funct3 size codes, LSU state type, byte-enable and store-lane helpers
package soc_lsu_pkg;
  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;
  function automatic logic [3:0] be_for(input logic [2:0] size, input logic [1:0] off);
    return size == SIZE_W ? 4'b1111 : (size[0] ? 4'b0011 : 4'b0001) << off;
  endfunction
  function automatic logic [31:0] wdata_for(input logic [2:0] size, input logic [31:0] w);
    return size == SIZE_W ? w : size[0] ? {2{w[15:0]}} : {4{w[7:0]}};
  endfunction
endpackage

// File: rtl/soc_lsu_load_extend.sv
// soc_lsu_load_extend: picks the byte/half at off from rdata and sign/zero-extends it per funct3 size
module soc_lsu_load_extend
  import soc_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  output logic [31:0] data
);
  logic [15:0] h;
  logic [7:0]  b;
  always_comb begin
    h = off[1] ? rdata[31:16] : rdata[15:0];
    b = off[0] ? h[15:8] : h[7:0];
    data = size[1] ? rdata
         : size[0] ? {{16{~size[2] & h[15]}}, h}
         : {{24{~size[2] & b[7]}}, b};
  end
endmodule

// File: rtl/soc_lsu.sv
// soc_lsu: core load/store to single-cycle bus request with ack wait, timeout fault, misalign/illegal reject
module soc_lsu
  import soc_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_stall_o,
  output logic        lsu_misalign_o,
  output logic        lsu_fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  lsu_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] size_q;
  logic [1:0] off_q;
  logic [31:0] ext;
  logic idle_req, illegal, misalign, accept, done, timeout;
  soc_lsu_load_extend u_ext (.rdata(bus_rdata_i), .size(size_q), .off(off_q), .data(ext));
  always_comb begin
    illegal = !(lsu_size_i inside {SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU}) || (lsu_we_i && lsu_size_i[2]);
    misalign = (lsu_size_i[0] && lsu_addr_i[0]) || (lsu_size_i == SIZE_W && lsu_addr_i[1:0] != 2'b00);
    idle_req = state == IDLE && lsu_req_i;
    accept = idle_req && !illegal && !misalign;
    done = state == WAIT && bus_ack_i;
    timeout = state == WAIT && !bus_ack_i && cnt == CW'(TIMEOUT_CYCLES - 1);
    lsu_fault_o = (idle_req && illegal) || timeout;
    lsu_misalign_o = idle_req && !illegal && misalign;
    lsu_stall_o = accept || state == REQ || (state == WAIT && !bus_ack_i && !timeout);
    lsu_rdata_o = done && !bus_we_o ? ext : 32'h0;
    bus_req_o = state == REQ;
    state_n = accept ? REQ
            : state == REQ ? WAIT
            : (done || timeout) ? IDLE
            : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      size_q <= '0;
      off_q <= '0;
      bus_we_o <= 1'b0;
      bus_be_o <= '0;
      bus_addr_o <= '0;
      bus_wdata_o <= '0;
    end else begin
      state <= state_n;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (accept) begin
        size_q <= lsu_size_i;
        off_q <= lsu_addr_i[1:0];
        bus_we_o <= lsu_we_i;
        bus_be_o <= be_for(lsu_size_i, lsu_addr_i[1:0]);
        bus_addr_o <= {lsu_addr_i[31:2], 2'b00};
        bus_wdata_o <= wdata_for(lsu_size_i, lsu_wdata_i);
      end
    end
  end
endmodule

// File: doc/soc_lsu.md
Name: soc_lsu

Overview:
Load/store unit sitting directly upstream of the on-chip memory's data bus port. It accepts one load/store per request from the core's execute stage and translates size and offset into bus byte-enables and lane-replicated write data. It issues a single-cycle bus request, waits for the ack, then returns sign- or zero-extended load data. The core is held in stall until the access completes, faults or is rejected.

Parameters:
TIMEOUT_CYCLES, 16, max cycles to wait in WAIT for bus_ack_i before aborting with a fault; must be ≥2.

Ports:
clk_i  in  1  system clock; same clock as the bus
rst_i  in  1  synchronous, active-high reset
lsu_req_i  in  1  core requests a memory access; held stable while lsu_stall_o=1
lsu_we_i  in  1  1=store, 0=load
lsu_size_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr_i  in  32  byte address
lsu_wdata_i  in  32  store data, right-aligned
lsu_rdata_o  out  32  extended load data, valid in the completion cycle
lsu_stall_o  out  1  core must hold the request
lsu_misalign_o  out  1  misaligned access rejected, 1-cycle pulse
lsu_fault_o  out  1  illegal size or bus timeout, 1-cycle pulse
bus_req_o  out  1  bus request, exactly one cycle per access
bus_we_o  out  1  bus write enable
bus_be_o  out  4  byte enables
bus_addr_o  out  32  word address, bits [1:0] forced to 0
bus_wdata_o  out  32  lane-replicated store data
bus_rdata_i  in  32  bus read data, valid with ack
bus_ack_i  in  1  bus completion

Behaviour:
- Reset (sync, rst_i=1 at posedge): state=IDLE, timeout counter=0, all bus_* outputs=0. lsu_rdata_o, lsu_misalign_o and lsu_fault_o read 0 in the cycle after reset.
- FSM states: IDLE, REQ, WAIT.
- IDLE, lsu_req_i=1, legal size, aligned: latch we/size/addr[1:0] and compute be/wdata, then go to REQ. lsu_stall_o=1 combinationally in this cycle.
- IDLE, illegal size (011, 110, 111, or a store with 100/101): no bus access. lsu_fault_o=1 and lsu_stall_o=0 in the same cycle; stay in IDLE.
- IDLE, misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0): no bus access. lsu_misalign_o=1 and lsu_stall_o=0 in the same cycle. If both conditions hold, the illegal-size fault takes priority.
- REQ: bus_req_o=1 with registered we/be/addr/wdata for exactly one cycle, then go to WAIT. Counter cleared. lsu_stall_o=1.
- WAIT: bus_req_o=0, bus_* data held.
  - bus_ack_i=1: lsu_stall_o=0 and lsu_rdata_o is driven combinationally from bus_rdata_i (loads; stores return 0); go to IDLE.
  - No ack: counter increments. When counter reaches TIMEOUT_CYCLES-1 with no ack, lsu_fault_o=1 and lsu_stall_o=0; go to IDLE.
- Nominal latency against a 1-cycle-ack memory: accept (c0), REQ (c1), ack/complete (c2). That is 3 cycles with stall high in c0–c1.
- Byte enables:
  - B/BU: 4'b0001<<off
  - H/HU: 4'b0011<<off
  - W: 4'b1111
- Write data:
  - B: {4{wdata[7:0]}}
  - H: {2{wdata[15:0]}}
  - W: unchanged
- Load extraction: take the byte or half selected by the latched off. B/H sign-extend; BU/HU zero-extend; W passes through.
- Ack arriving in IDLE or REQ is ignored.
- Back-to-back requests: a new request is accepted in the cycle after completion, never in the completion cycle itself.
- Reset during REQ/WAIT: returns to IDLE. A bus request already issued is abandoned and its late ack is ignored.

Decomposition:
- soc_lsu_pkg:
  - funct3 localparams: SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU.
  - lsu_state_t enum {IDLE, REQ, WAIT}.
  - Helper function be_for(size, off).
- One combinational sub-module soc_lsu_load_extend (rdata, size, off → extended data), reused by the load path and the bench's reference model.

Test Plan:
- Preload word 0x10 = 0x8899AABB; LB addr 0x13 → lsu_rdata_o=0xFFFFFF88 in c2; stall high c0–c1 only.
- LBU 0x12 → 0x00000099; LHU 0x12 → 0x00008899; LH 0x10 → 0xFFFFAABB; LW 0x10 → 0x8899AABB.
- SB 0x21 wdata=0x000000CC over word 0x20=0x11223344:
  - Bus shows be=0010, wdata=0xCCCCCCCC, addr=0x20, req for 1 cycle.
  - Subsequent LW 0x20 → 0x1122CC44.
- LW 0x22 → lsu_misalign_o=1 same cycle, stall 0, bus_req_o never asserted. Size 011 → lsu_fault_o=1, no bus activity.
- Bus slave that never acks, TIMEOUT_CYCLES=16 → lsu_fault_o pulses in the 16th WAIT cycle, FSM back in IDLE. A late ack afterwards causes no output change.
- Assert rst_i in WAIT, then ack arrives next cycle → outputs stay 0, state IDLE. The next LW completes normally.
